mc_main_control: RTL
====================

Name: mc_main_control

Overview:
- Multicycle main control FSM. Produces the ALUOp code consumed by ALU_Control, plus all datapath enables and mux selects for the multicycle MIPS-style datapath.
- Sits between the instruction register opcode field and the datapath.
- Moore machine: every control output decodes from the state register only.
- Adds a memory stall hook and an illegal-opcode flag.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode
OP_ADDI, 6'b001000, add-immediate opcode (used only with ADDI_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
stall  input  1  memory not ready; freeze FSM
PCWrite  output  1  unconditional PC write
PCWriteCond  output  1  PC write if ALU zero
IorD  output  1  memory address select (0=PC, 1=ALUOut)
MemRead  output  1  memory read
MemWrite  output  1  memory write
MemtoReg  output  1  write-back data select (1=MDR)
IRWrite  output  1  IR load
PCSource  output  2  00=ALU, 01=ALUOut, 10=jump target
ALUOp  output  2  to ALU_Control: 00 add, 01 sub, 10 funct
ALUSrcA  output  1  0=PC, 1=A
ALUSrcB  output  2  00=B, 01=4, 10=signext, 11=signext<<2
RegWrite  output  1  register file write
RegDst  output  1  1=rd, 0=rt
instr_done  output  1  high in the final state of each instruction
illegal_op  output  1  one-cycle pulse after an unknown opcode is decoded
state  output  4  current state, for debug

Behaviour:
- Reset (rst_n=0, asynchronous): state=RESET(4'd15) and illegal_op=0. All outputs are 0 in RESET.
- RESET always moves to FETCH on the next clock, regardless of stall.
- State encoding: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, RESET 15.
- Per-state outputs (any signal not listed is 0):
  - FETCH: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
  - DECODE: ALUSrcB=11.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10.
  - MEM_READ: MemRead=1, IorD=1.
  - MEM_WB: RegWrite=1, MemtoReg=1, instr_done=1.
  - MEM_WRITE: MemWrite=1, IorD=1, instr_done=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - R_WB: RegWrite=1, RegDst=1, instr_done=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1.
  - JUMP: PCWrite=1, PCSource=10, instr_done=1.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10.
  - ADDI_WB: RegWrite=1, instr_done=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: LW/SW -> MEM_ADDR; RTYPE -> EXECUTE; BEQ -> BRANCH; J -> JUMP; any other opcode -> FETCH.
  - MEM_ADDR -> MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ -> MEM_WB.
  - EXECUTE -> R_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB -> FETCH.
- Opcode is sampled in DECODE and again in MEM_ADDR. It is not used in any other state.
- Latency in cycles from FETCH to the return to FETCH, stall=0: LW 5, SW 4, R 4, BEQ 3, J 3, ADDI 4.
- Stall: when stall=1 in any state other than RESET:
  - State holds.
  - PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite and instr_done are forced to 0.
  - MemRead, IorD and all mux selects keep their state values.
  - Stall applies in DECODE too; the illegal-opcode decision is deferred until stall=0.
- illegal_op:
  - Registered.
  - Goes to 1 in the cycle after a DECODE exit with an unknown opcode, i.e. the next FETCH cycle. Cleared the following cycle.
  - Unaffected by stall once set; still cleared after one cycle.
- Reset asserted mid-instruction: immediate return to RESET with all outputs 0. No partial write completes after the reset edge.

Optional Feature:
- Macro ADDI_EN.
- Defined: DECODE with opcode=OP_ADDI -> ADDI_EXEC -> ADDI_WB -> FETCH (4 cycles).
- Not defined: OP_ADDI is treated as illegal; states 10/11 are unreachable and not decoded.

Test Plan:
- Reset, then opcode=000000, stall=0 -> state sequence 15,0,1,6,7,0; ALUOp=10 in EXECUTE; RegWrite=1 and RegDst=1 only in R_WB.
- opcode=100011 -> 0,1,2,3,4,0; MemRead=1 in FETCH and MEM_READ; MemtoReg=1 and instr_done=1 in MEM_WB. opcode=101011 -> 0,1,2,5,0 with MemWrite=1, IorD=1 in state 5.
- opcode=000100 -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01. opcode=000010 -> JUMP with PCWrite=1, PCSource=10. Each returns to FETCH after 3 cycles.
- opcode=111111 -> DECODE then FETCH; illegal_op=1 for exactly that FETCH cycle. With ADDI_EN undefined, opcode=001000 gives the same result; with ADDI_EN defined it gives states 10,11.
- stall=1 for 3 cycles in MEM_READ -> state stays 3, MemRead=1, no write enables; MEM_WB follows the cycle after stall drops. Stall in FETCH -> IRWrite=0 and PCWrite=0 while held.
- rst_n pulled low asynchronously mid-EXECUTE -> state=15 and all outputs 0 before the next clock edge; FETCH resumes one cycle after rst_n rises.

Source files
------------

// File: rtl/mc_main_control.sv
// Multicycle MIPS-style main control FSM with memory stall hook and illegal-opcode flag.
// Optional ADDI support is enabled by defining the macro ADDI_EN.
module mc_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       stall,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_RESET     = 4'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_q, illegal_d;
  logic   hold;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE:    c.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.instr_done    = 1'b1;
      end
      S_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.instr_done = 1'b1;
      end
`ifdef ADDI_EN
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  // Outputs are registered from the next state so they stay a pure function of state_q.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    if (state_q == S_RESET) begin
      state_d = S_FETCH;
    end else if (!stall) begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
            OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
            default: begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          if (opcode == OP_LW)      state_d = S_MEM_READ;
          else if (opcode == OP_SW) state_d = S_MEM_WRITE;
          else                      state_d = S_FETCH;
        end
        S_MEM_READ: state_d = S_MEM_WB;
        S_EXECUTE:  state_d = S_R_WB;
`ifdef ADDI_EN
        S_ADDI_EXEC: state_d = S_ADDI_WB;
`endif
        default: state_d = S_FETCH;
      endcase
    end
    ctrl_d = decode_ctrl(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  // A stall suppresses every side-effecting strobe but leaves selects and reads alone.
  assign hold = stall && (state_q != S_RESET);

  assign PCWrite     = ctrl_q.pc_write      & ~hold;
  assign PCWriteCond = ctrl_q.pc_write_cond & ~hold;
  assign IRWrite     = ctrl_q.ir_write      & ~hold;
  assign MemWrite    = ctrl_q.mem_write     & ~hold;
  assign RegWrite    = ctrl_q.reg_write     & ~hold;
  assign instr_done  = ctrl_q.instr_done    & ~hold;
  assign IorD        = ctrl_q.i_or_d;
  assign MemRead     = ctrl_q.mem_read;
  assign MemtoReg    = ctrl_q.mem_to_reg;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUOp       = ctrl_q.alu_op;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign RegDst      = ctrl_q.reg_dst;
  assign illegal_op  = illegal_q;
  assign state       = state_q;

endmodule
